// File: rtl/pe_seq_ctrl.sv
// Sequencer for a bit-serial PE column. It steps through clear, weight load,
// k_len multiply-accumulate passes of MCYC cycles each, a drain flush, and a done pulse.
module pe_seq_ctrl #(
  parameter int IDEPTH = 4,
  parameter int MCYC   = 16,
  parameter int KWIDTH = 16,
  parameter int DRAIN  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [KWIDTH-1:0] k_len,
  input  logic              w_load,
  input  logic              hold,
  output logic              ready,
  output logic              busy,
  output logic              done,
  output logic [IDEPTH-1:0] idx,
  output logic              mac_done,
  output logic              en_i,
  output logic              clr_i,
  output logic              en_w,
  output logic              clr_w,
  output logic              en_o,
  output logic              clr_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_WLD,
    S_MAC,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam int DW = (DRAIN > 1) ? $clog2(DRAIN) : 1;
  localparam logic [IDEPTH-1:0] C_LAST = IDEPTH'(MCYC - 1);
  localparam logic [DW-1:0]     D_LAST = DW'(DRAIN - 1);

  state_t            state_q, state_d;
  logic [IDEPTH-1:0] c_q, c_d;
  logic [KWIDTH-1:0] k_q, k_d;
  logic [DW-1:0]     d_q, d_d;
  logic [KWIDTH-1:0] k_len_q;
  logic              w_load_q;

  logic c_last, k_last;
  assign c_last = (c_q == C_LAST);
  assign k_last = (k_q == k_len_q - KWIDTH'(1));

  // NOTE: every signal driven here gets a default first, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    c_d      = c_q;
    k_d      = k_q;
    d_d      = d_q;
    ready    = 1'b0;
    done     = 1'b0;
    idx      = '0;
    mac_done = 1'b0;
    en_i     = 1'b0;
    clr_i    = 1'b0;
    en_w     = 1'b0;
    clr_w    = 1'b0;
    en_o     = 1'b0;
    clr_o    = 1'b0;

    case (state_q)
      S_IDLE: begin
        ready = 1'b1;
        if (start) state_d = S_CLR;
      end
      S_CLR: begin
        clr_i = 1'b1;
        clr_o = 1'b1;
        clr_w = w_load_q;
        c_d   = '0;
        k_d   = '0;
        if (w_load_q)           state_d = S_WLD;
        else if (k_len_q != '0) state_d = S_MAC;
        else                    state_d = S_DONE;
      end
      S_WLD: begin
        en_w    = 1'b1;
        state_d = (k_len_q != '0) ? S_MAC : S_DONE;
      end
      S_MAC: begin
        // A stall freezes the counters and masks every strobe; idx still shows c.
        idx = c_q;
        if (!hold) begin
          en_i     = (c_q == '0);
          en_o     = c_last;
          mac_done = c_last && k_last;
          if (c_last) begin
            c_d = '0;
            if (k_last) begin
              d_d     = '0;
              state_d = S_DRAIN;
            end else begin
              k_d = k_q + KWIDTH'(1);
            end
          end else begin
            c_d = c_q + IDEPTH'(1);
          end
        end
      end
      S_DRAIN: begin
        if (d_q == D_LAST) state_d = S_DONE;
        else               d_d     = d_q + DW'(1);
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy = ~ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      c_q      <= '0;
      k_q      <= '0;
      d_q      <= '0;
      k_len_q  <= '0;
      w_load_q <= 1'b0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      k_q     <= k_d;
      d_q     <= d_d;
      if (state_q == S_IDLE && start) begin
        k_len_q  <= k_len;
        w_load_q <= w_load;
      end
    end
  end

endmodule

// File: tb/tb_pe_seq_ctrl.sv
// Directed bench for pe_seq_ctrl with MCYC=4 and DRAIN=2. Per-cycle vector tables
// cover whole jobs, and hand-written sequences cover ignored start, mid-job reset and restart.
module tb_pe_seq_ctrl;
  localparam int IDEPTH = 4;
  localparam int MCYC   = 4;
  localparam int KWIDTH = 16;
  localparam int DRAIN  = 2;

  logic              clk = 1'b0;
  logic              rst, start, w_load, hold;
  logic [KWIDTH-1:0] k_len;
  logic              ready, busy, done, mac_done;
  logic              en_i, clr_i, en_w, clr_w, en_o, clr_o;
  logic [IDEPTH-1:0] idx;

  pe_seq_ctrl #(.IDEPTH(IDEPTH), .MCYC(MCYC), .KWIDTH(KWIDTH), .DRAIN(DRAIN)) dut (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len), .w_load(w_load), .hold(hold),
    .ready(ready), .busy(busy), .done(done), .idx(idx), .mac_done(mac_done),
    .en_i(en_i), .clr_i(clr_i), .en_w(en_w), .clr_w(clr_w), .en_o(en_o), .clr_o(clr_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        start, hold, w_load;
    logic [15:0] k_len;
    logic        ready, done;
    logic [3:0]  idx;
    logic        mac_done, en_i, en_o, en_w;
    logic [2:0]  clr;   // {clr_i, clr_w, clr_o}
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic void add(input logic st, hd, wl, input int kl,
                              input logic rdy, dn, input int ix,
                              input logic md, ei, eo, ew, input logic [2:0] cl);
    vec_t v;
    v.start = st; v.hold = hd; v.w_load = wl; v.k_len = 16'(kl);
    v.ready = rdy; v.done = dn; v.idx = 4'(ix);
    v.mac_done = md; v.en_i = ei; v.en_o = eo; v.en_w = ew; v.clr = cl;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, want %b", name, act, exp);
    end
  endtask

  function automatic logic [13:0] outs();
    return {ready, busy, done, idx, mac_done, en_i, en_o, en_w, clr_i, clr_w, clr_o};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int lat;
    int n_done;

    // Job: k_len=3, w_load=1, no stall.
    add(1,0,1,3, 1,0,0, 0,0,0,0, 3'b000);
    add(0,0,1,3, 0,0,0, 0,0,0,0, 3'b111);
    add(0,0,1,3, 0,0,0, 0,0,0,1, 3'b000);
    add(0,0,1,3, 0,0,0, 0,1,0,0, 3'b000);
    add(0,0,1,3, 0,0,1, 0,0,0,0, 3'b000);
    add(0,0,1,3, 0,0,2, 0,0,0,0, 3'b000);
    add(0,0,1,3, 0,0,3, 0,0,1,0, 3'b000);
    add(0,0,1,3, 0,0,0, 0,1,0,0, 3'b000);
    add(0,0,1,3, 0,0,1, 0,0,0,0, 3'b000);
    add(0,0,1,3, 0,0,2, 0,0,0,0, 3'b000);
    add(0,0,1,3, 0,0,3, 0,0,1,0, 3'b000);
    add(0,0,1,3, 0,0,0, 0,1,0,0, 3'b000);
    add(0,0,1,3, 0,0,1, 0,0,0,0, 3'b000);
    add(0,0,1,3, 0,0,2, 0,0,0,0, 3'b000);
    add(0,0,1,3, 0,0,3, 1,0,1,0, 3'b000);
    add(0,0,1,3, 0,0,0, 0,0,0,0, 3'b000);
    add(0,0,1,3, 0,0,0, 0,0,0,0, 3'b000);
    add(0,0,1,3, 0,1,0, 0,0,0,0, 3'b000);
    add(0,0,1,3, 1,0,0, 0,0,0,0, 3'b000);
    // Same job, hold in cycles 5-6. After the start cycle, k_len and w_load are
    // changed to junk to confirm that the values were captured at start.
    add(1,0,1,3, 1,0,0, 0,0,0,0, 3'b000);
    add(0,0,0,7, 0,0,0, 0,0,0,0, 3'b111);
    add(0,0,0,7, 0,0,0, 0,0,0,1, 3'b000);
    add(0,0,0,7, 0,0,0, 0,1,0,0, 3'b000);
    add(0,0,0,7, 0,0,1, 0,0,0,0, 3'b000);
    add(0,1,0,7, 0,0,2, 0,0,0,0, 3'b000);
    add(0,1,0,7, 0,0,2, 0,0,0,0, 3'b000);
    add(0,0,0,7, 0,0,2, 0,0,0,0, 3'b000);
    add(0,0,0,7, 0,0,3, 0,0,1,0, 3'b000);
    add(0,0,0,7, 0,0,0, 0,1,0,0, 3'b000);
    add(0,0,0,7, 0,0,1, 0,0,0,0, 3'b000);
    add(0,0,0,7, 0,0,2, 0,0,0,0, 3'b000);
    add(0,0,0,7, 0,0,3, 0,0,1,0, 3'b000);
    add(0,0,0,7, 0,0,0, 0,1,0,0, 3'b000);
    add(0,0,0,7, 0,0,1, 0,0,0,0, 3'b000);
    add(0,0,0,7, 0,0,2, 0,0,0,0, 3'b000);
    add(0,0,0,7, 0,0,3, 1,0,1,0, 3'b000);
    add(0,1,0,7, 0,0,0, 0,0,0,0, 3'b000);
    add(0,0,0,7, 0,0,0, 0,0,0,0, 3'b000);
    add(0,0,0,7, 0,1,0, 0,0,0,0, 3'b000);
    add(0,0,0,7, 1,0,0, 0,0,0,0, 3'b000);
    // Empty job (k_len=0, w_load=0), with hold held high the whole time.
    add(1,1,0,0, 1,0,0, 0,0,0,0, 3'b000);
    add(0,1,0,0, 0,0,0, 0,0,0,0, 3'b101);
    add(0,1,0,0, 0,1,0, 0,0,0,0, 3'b000);
    add(0,1,0,0, 1,0,0, 0,0,0,0, 3'b000);
    // Weight-only job (k_len=0, w_load=1).
    add(1,0,1,0, 1,0,0, 0,0,0,0, 3'b000);
    add(0,0,1,0, 0,0,0, 0,0,0,0, 3'b111);
    add(0,0,1,0, 0,0,0, 0,0,0,1, 3'b000);
    add(0,0,1,0, 0,1,0, 0,0,0,0, 3'b000);
    add(0,0,1,0, 1,0,0, 0,0,0,0, 3'b000);

    // Reset: rst high for two cycles, then released.
    rst = 1'b1; start = 1'b0; w_load = 1'b0; hold = 1'b0; k_len = '0;
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("reset_state", 32'(outs()), 32'({1'b1, 1'b0, 12'b0}));
    tick();

    foreach (vecs[i]) begin
      start  = vecs[i].start;
      hold   = vecs[i].hold;
      w_load = vecs[i].w_load;
      k_len  = vecs[i].k_len;
      @(negedge clk);
      check($sformatf("row%0d", i), 32'(outs()),
            32'({vecs[i].ready, ~vecs[i].ready, vecs[i].done, vecs[i].idx,
                 vecs[i].mac_done, vecs[i].en_i, vecs[i].en_o, vecs[i].en_w, vecs[i].clr}));
      tick();
    end
    start = 1'b0; hold = 1'b0;

    // Protocol: start at cycle 0, ignored start at cycle 5, rst at cycle 9.
    start = 1'b1; k_len = 16'd3; w_load = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick(); tick();
    start = 1'b1; k_len = 16'd1; w_load = 1'b0;       // cycle 5
    @(negedge clk);
    check("busy_c5", 32'({busy, idx}), 32'({1'b1, 4'd2}));
    tick();
    start = 1'b0;                                      // cycle 6
    @(negedge clk);
    check("ignored_start_c6", 32'({clr_i, idx, en_o}), 32'({1'b0, 4'd3, 1'b1}));
    tick(); tick(); tick();
    rst = 1'b1;                                        // cycle 9
    @(negedge clk);
    check("pre_reset_c9", 32'({busy, idx}), 32'({1'b1, 4'd2}));
    tick();
    rst = 1'b0;                                        // cycle 10
    @(negedge clk);
    check("reset_idle_c10", 32'(outs()), 32'({1'b1, 1'b0, 12'b0}));
    n_done = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      @(negedge clk);
      if (done) n_done++;
    end
    check("no_done_after_reset", 32'(n_done), 32'd0);

    // Restart with k_len=1, w_load=0: done is expected at cycle 1+4+2+1 = 8.
    tick();
    start = 1'b1; k_len = 16'd1; w_load = 1'b0;
    @(negedge clk);
    check("restart_ready", 32'(ready), 32'd1);
    tick();
    start = 1'b0;
    lat = -1;
    for (int i = 1; i <= 20 && lat < 0; i++) begin
      @(negedge clk);
      if (done) lat = i;
      tick();
    end
    check("restart_latency", 32'(lat), 32'd8);
    @(negedge clk);
    check("restart_back_idle", 32'(ready), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/pe_seq_ctrl.md
PE_SEQ_CTRL -- requirements
Module: pe_seq_ctrl

Interface
REQ-001 SHALL have parameter IDEPTH, default 4, giving the width of idx.
REQ-002 SHALL have parameter MCYC, default 16, giving cycles per bit-serial multiply; legal range 2..2^IDEPTH.
REQ-003 SHALL have parameter KWIDTH, default 16, giving the width of the MAC-count field.
REQ-004 SHALL have parameter DRAIN, default 2, giving post-MAC flush cycles; minimum 1.
REQ-005 SHALL have one clock; reset is synchronous and active-high.
REQ-006 clk  input  1  rising-edge clock for all state.
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 start  input  1  job request; sampled only when ready=1.
REQ-009 k_len  input  KWIDTH  number of MACs per output, captured with start.
REQ-010 w_load  input  1  reload-weight flag, captured with start.
REQ-011 hold  input  1  stalls the MAC state (upstream data not available).
REQ-012 ready  output  1  high in IDLE only.
REQ-013 busy  output  1  equals not ready.
REQ-014 done  output  1  one-cycle job-complete pulse.
REQ-015 idx  output  IDEPTH  multiply cycle index to the PE column.
REQ-016 Outputs mac_done, en_i, clr_i, en_w, clr_w, en_o and clr_o SHALL each be 1-bit and drive the same-named PE column controls.

Function
REQ-017 States SHALL be IDLE, CLR, WLD, MAC, DRAIN and DONE.
REQ-018 start=1 in IDLE SHALL latch k_len and w_load and move to CLR; start outside IDLE SHALL be ignored.
REQ-019 CLR SHALL last 1 cycle with clr_i=clr_w=clr_o=1 when the latched w_load=1, and with clr_i=clr_o=1 and clr_w=0 otherwise.
REQ-020 From CLR the block SHALL go to WLD if w_load=1, else to MAC if k_len>0, else to DONE.
REQ-021 WLD SHALL last 1 cycle with en_w=1, then go to MAC, or to DONE if k_len=0.
REQ-022 MAC SHALL keep idx counter c (0..MCYC-1) and element counter k (0..k_len-1), both 0 on entry.
REQ-023 Each non-held MAC cycle SHALL wrap c from MCYC-1 to 0 and increment k on that wrap.
REQ-024 In MAC, idx SHALL equal c, en_i SHALL be 1 when c=0, and en_o SHALL be 1 when c=MCYC-1.
REQ-025 mac_done SHALL be 1 only when c=MCYC-1 and k=k_len-1.
REQ-026 After the cycle with c=MCYC-1 and k=k_len-1 the block SHALL go to DRAIN.
REQ-027 A job SHALL spend exactly k_len*MCYC non-held cycles in MAC.
REQ-028 hold=1 in MAC SHALL freeze c and k, keep idx at c, and force en_i, en_o and mac_done to 0.
REQ-029 hold SHALL be ignored in every state other than MAC.
REQ-030 DRAIN SHALL last exactly DRAIN cycles with all enables and clears at 0, then go to DONE.
REQ-031 DONE SHALL last 1 cycle with done=1, then go to IDLE.
REQ-032 idx SHALL be 0 outside MAC.
REQ-033 Every en_* and clr_* output SHALL be 0 except where this section asserts it.
REQ-034 All outputs SHALL be registered, or decoded only from registered state and the hold input.
REQ-035 Latency from start accepted at cycle T to done SHALL be T + 1 + w_load + k_len*MCYC + DRAIN + 1, plus held cycles, when k_len>0.

Reset
REQ-036 rst=1 SHALL force IDLE on the next edge and clear c, k and the latched fields, regardless of state.
REQ-037 After reset, ready=1 and every other output, including idx, SHALL be 0.
REQ-038 A job interrupted by rst SHALL not produce done.

Verification
(all scenarios use MCYC=4, DRAIN=2)
REQ-039 Reset: rst high 2 cycles, then low -> ready=1, busy=0, idx=0, every other output 0.
REQ-040 Job: start at cycle 0 with k_len=3, w_load=1 -> clr_* at 1; en_w at 2; en_i at 3, 7, 11; en_o at 6, 10, 14; mac_done at 14 only; done at 17; ready at 18.
REQ-041 Stall: same job with hold=1 during cycles 5-6 -> idx holds at 2 through cycle 7; en_o at 8, 12, 16; done at 19.
REQ-042 Empty job: start with k_len=0, w_load=0 -> clr_i and clr_o at 1 (clr_w=0); done at 2; en_i and en_o never asserted.
REQ-043 Protocol: start pulsed at cycle 5 during a job is ignored; rst at cycle 9 -> IDLE at 10, no done, next start accepted normally.
